// File: rtl/dht11_pkg.sv
// Shared types, constants and helpers for the DHT11 single-wire reader.
//   dht11_state_e   : reader FSM states
//   dht11_reading_t : published 32-bit reading {hum_int, hum_dec, temp_int, temp_dec}
//   us_to_cycles    : microseconds to clock cycles at a given clock frequency
//   frame_sum       : 8-bit wrapping sum of the four payload bytes of a 40-bit frame
package dht11_pkg;

  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned READING_W  = 32;

  // Byte lanes within the 40-bit frame (lane 4 is received first).
  localparam int unsigned CHECKSUM = 0;
  localparam int unsigned TEMP_DEC = 1;
  localparam int unsigned TEMP_INT = 2;
  localparam int unsigned HUM_DEC  = 3;
  localparam int unsigned HUM_INT  = 4;

  typedef enum logic [3:0] {
    ST_POWERUP,
    ST_START_LOW,
    ST_RESP_WAIT,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_CHECK,
    ST_IDLE
  } dht11_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] hum_int;
    logic [BYTE_W-1:0] hum_dec;
    logic [BYTE_W-1:0] temp_int;
    logic [BYTE_W-1:0] temp_dec;
  } dht11_reading_t;

  function automatic int unsigned us_to_cycles(input int unsigned clk_freq,
                                               input int unsigned us);
    return (clk_freq / 32'd1_000_000) * us;
  endfunction

  // Checksum is the plain byte sum truncated to 8 bits.
  function automatic logic [BYTE_W-1:0] frame_sum(input logic [FRAME_BITS-1:0] frame);
    return frame[HUM_INT*BYTE_W  +: BYTE_W] + frame[HUM_DEC*BYTE_W  +: BYTE_W] +
           frame[TEMP_INT*BYTE_W +: BYTE_W] + frame[TEMP_DEC*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// Two-flop synchronizer for the sensor line plus rise/fall edge strobes.
//   clk, reset_n : clock and async active-low reset
//   line         : raw (asynchronous) single-wire level
//   rise_c       : one-cycle strobe on a synchronized 0->1 transition
//   fall_c       : one-cycle strobe on a synchronized 1->0 transition
// Strobes are combinational from registers so sensor edge to strobe is 2 clocks.
module dht11_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic line,
  output logic rise_c,
  output logic fall_c
);

  logic sync_q1;
  logic sync_q2;
  logic prev_q;

  // Flops reset high to match the pulled-up idle line, avoiding a spurious edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync_q1 <= line;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign rise_c = sync_q2 & ~prev_q;
  assign fall_c = ~sync_q2 & prev_q;

endmodule

// File: rtl/dht11_reader.sv
// DHT11 front end: host start pulse, pulse-width bit decode, checksum, reading publish.
//   clk, reset_n : clock and async active-low reset
//   dht_data     : open-drain sensor line (driven 0 or released to z)
//   sensor_data  : {hum_int, hum_dec, temp_int, temp_dec} of the last good frame
//   data_valid   : sticky, set on the first good frame
//   data_update  : one-cycle pulse per good frame
//   checksum_err : one-cycle pulse per frame with a bad checksum
//   timeout_err  : one-cycle pulse when a sensor-driven phase runs too long
module dht11_reader
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 12_000_000,
  parameter int unsigned POWERUP_US    = 1_000_000,
  parameter int unsigned POLL_US       = 2_000_000,
  parameter int unsigned START_LOW_US  = 18_000,
  parameter int unsigned BIT_THRESH_US = 50,
  parameter int unsigned TIMEOUT_US    = 200
) (
  input  logic                 clk,
  input  logic                 reset_n,
  inout  wire                  dht_data,
  output logic [READING_W-1:0] sensor_data,
  output logic                 data_valid,
  output logic                 data_update,
  output logic                 checksum_err,
  output logic                 timeout_err
);

  localparam int unsigned POWERUP_CYC = us_to_cycles(CLK_FREQ, POWERUP_US);
  localparam int unsigned POLL_CYC    = us_to_cycles(CLK_FREQ, POLL_US);
  localparam int unsigned START_CYC   = us_to_cycles(CLK_FREQ, START_LOW_US);
  localparam int unsigned THRESH_CYC  = us_to_cycles(CLK_FREQ, BIT_THRESH_US);
  localparam int unsigned TIMEOUT_CYC = us_to_cycles(CLK_FREQ, TIMEOUT_US);
  localparam int unsigned MAX_A       = (POWERUP_CYC > POLL_CYC) ? POWERUP_CYC : POLL_CYC;
  localparam int unsigned MAX_B       = (START_CYC > TIMEOUT_CYC) ? START_CYC : TIMEOUT_CYC;
  localparam int unsigned MAX_C       = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC     = (MAX_C > THRESH_CYC) ? MAX_C : THRESH_CYC;
  localparam int unsigned CNT_W       = $clog2(MAX_CYC + 1);
  localparam int unsigned BIT_CNT_W   = 6;

  dht11_state_e           state;
  dht11_state_e           state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [CNT_W-1:0]       cnt_inc;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt_nxt;
  logic [FRAME_BITS-1:0]  shreg;
  logic [FRAME_BITS-1:0]  shreg_nxt;
  dht11_reading_t         reading;
  dht11_reading_t         reading_nxt;
  logic                   drive_low;
  logic                   drive_low_nxt;
  logic                   valid_nxt;
  logic                   update_nxt;
  logic                   cksum_nxt;
  logic                   timeout_nxt;
  logic                   expired;
  logic                   rise_c;
  logic                   fall_c;

  // Open-drain pin: only ever pull low, otherwise release.
  assign dht_data = drive_low ? 1'b0 : 1'bz;

  dht11_line_sync u_line_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .line    (dht_data),
    .rise_c  (rise_c),
    .fall_c  (fall_c)
  );

  // Next-state, counter and output logic.
  always_comb begin
    state_nxt     = state;
    cnt_inc       = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    cnt_nxt       = cnt_inc;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    reading_nxt   = reading;
    drive_low_nxt = drive_low;
    valid_nxt     = data_valid;
    update_nxt    = 1'b0;
    cksum_nxt     = 1'b0;
    timeout_nxt   = 1'b0;
    // A phase has lasted TIMEOUT_CYC cycles once the incremented count gets there.
    expired       = (cnt_inc >= CNT_W'(TIMEOUT_CYC));

    case (state)
      ST_POWERUP: begin
        if (cnt == CNT_W'(POWERUP_CYC - 1)) begin
          state_nxt     = ST_START_LOW;
          cnt_nxt       = '0;
          drive_low_nxt = 1'b1;
        end
      end
      ST_START_LOW: begin
        if (cnt == CNT_W'(START_CYC - 1)) begin
          state_nxt     = ST_RESP_WAIT;
          cnt_nxt       = '0;
          drive_low_nxt = 1'b0;
        end
      end
      ST_RESP_WAIT, ST_RESP_HIGH: begin
        // Edge takes priority over a coincident timeout.
        if (fall_c) begin
          state_nxt = (state == ST_RESP_WAIT) ? ST_RESP_LOW : ST_BIT_LOW;
          cnt_nxt   = '0;
          if (state == ST_RESP_HIGH) begin
            bit_cnt_nxt = '0;
            shreg_nxt   = '0;
          end
        end else if (expired) begin
          state_nxt   = ST_IDLE;
          cnt_nxt     = '0;
          timeout_nxt = 1'b1;
        end
      end
      ST_RESP_LOW, ST_BIT_LOW: begin
        if (rise_c) begin
          state_nxt = (state == ST_RESP_LOW) ? ST_RESP_HIGH : ST_BIT_HIGH;
          cnt_nxt   = '0;
        end else if (expired) begin
          state_nxt   = ST_IDLE;
          cnt_nxt     = '0;
          timeout_nxt = 1'b1;
        end
      end
      ST_BIT_HIGH: begin
        // cnt_inc equals the high width in cycles, strobe to strobe.
        if (fall_c) begin
          shreg_nxt   = {shreg[FRAME_BITS-2:0], (cnt_inc > CNT_W'(THRESH_CYC))};
          bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
          cnt_nxt     = '0;
          state_nxt   = (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) ? ST_CHECK : ST_BIT_LOW;
        end else if (expired) begin
          state_nxt   = ST_IDLE;
          cnt_nxt     = '0;
          timeout_nxt = 1'b1;
        end
      end
      ST_CHECK: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        if (frame_sum(shreg) == shreg[CHECKSUM*BYTE_W +: BYTE_W]) begin
          reading_nxt.hum_int  = shreg[HUM_INT*BYTE_W  +: BYTE_W];
          reading_nxt.hum_dec  = shreg[HUM_DEC*BYTE_W  +: BYTE_W];
          reading_nxt.temp_int = shreg[TEMP_INT*BYTE_W +: BYTE_W];
          reading_nxt.temp_dec = shreg[TEMP_DEC*BYTE_W +: BYTE_W];
          valid_nxt            = 1'b1;
          update_nxt           = 1'b1;
        end else begin
          cksum_nxt = 1'b1;
        end
      end
      ST_IDLE: begin
        if (cnt == CNT_W'(POLL_CYC - 1)) begin
          state_nxt     = ST_START_LOW;
          cnt_nxt       = '0;
          drive_low_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt     = ST_POWERUP;
        cnt_nxt       = '0;
        drive_low_nxt = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset releases the line at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_POWERUP;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      reading      <= '0;
      drive_low    <= 1'b0;
      data_valid   <= 1'b0;
      data_update  <= 1'b0;
      checksum_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shreg        <= shreg_nxt;
      reading      <= reading_nxt;
      drive_low    <= drive_low_nxt;
      data_valid   <= valid_nxt;
      data_update  <= update_nxt;
      checksum_err <= cksum_nxt;
      timeout_err  <= timeout_nxt;
    end
  end

  assign sensor_data = reading;

endmodule
